// File: rtl/waffle_bus_arbiter.sv
// Two-master arbiter for the single WAFFLE memory port: CPU has default priority,
// the DMA master wins after STARVE_MAX consecutive lost contentions; reads return one cycle after grant.
module waffle_bus_arbiter #(
    parameter int RAM_LIMIT  = 900,
    parameter int SW_ADDR    = 998,
    parameter int LED_ADDR   = 999,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [7:0]  rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic [7:0]  sw,
    output logic [7:0]  led,
    output logic        bus_err
);
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int NREQ  = 2;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_SW   = 2'd2
    } src_t;

    // Requester index 0 is the CPU, index 1 the DMA master.
    logic [NREQ-1:0]  req_vec;
    logic [NREQ-1:0]  we_vec;
    logic [NREQ-1:0]  gnt_vec;
    logic [NREQ-1:0]  rd_gnt_vec;
    logic [NREQ-1:0]  pend_reg;
    logic [CNT_W-1:0] starve_cnt_reg;
    logic [CNT_W-1:0] starve_cnt_next;
    logic             starved;
    logic             grant_any;
    logic             g_we;
    logic [15:0]      g_addr;
    logic [7:0]       g_wdata;
    logic             hit_ram;
    logic             hit_sw;
    logic             hit_led;
    logic             hit_none;
    src_t             src_reg;
    src_t             src_next;
    logic [7:0]       sw_sample_reg;
    logic [7:0]       led_reg;
    logic [7:0]       rdata_last_reg;
    logic [7:0]       rdata_next;
    logic             bus_err_reg;

    assign req_vec = {dma_req, cpu_req};
    assign we_vec  = {dma_we, cpu_we};
    assign starved = (starve_cnt_reg == CNT_W'(STARVE_MAX));

    always_comb begin
        gnt_vec = '0;
        if (!rst) begin
            if (&req_vec) begin
                gnt_vec = starved ? 2'b10 : 2'b01;
            end else begin
                gnt_vec = req_vec;
            end
        end
    end

    assign cpu_gnt   = gnt_vec[0];
    assign dma_gnt   = gnt_vec[1];
    assign grant_any = |gnt_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rd_gnt
            assign rd_gnt_vec[gi] = gnt_vec[gi] & ~we_vec[gi];
        end
    endgenerate

    assign g_we    = gnt_vec[1] ? dma_we    : cpu_we;
    assign g_addr  = gnt_vec[1] ? dma_addr  : cpu_addr;
    assign g_wdata = gnt_vec[1] ? dma_wdata : cpu_wdata;

    assign hit_ram  = (g_addr < 16'(RAM_LIMIT));
    assign hit_sw   = (g_addr == 16'(SW_ADDR));
    assign hit_led  = (g_addr == 16'(LED_ADDR));
    assign hit_none = !(hit_ram || hit_sw || hit_led);

    // RAM-side outputs are zeroed whenever the access is not a RAM hit.
    assign mem_en    = grant_any & hit_ram;
    assign mem_we    = mem_en & g_we;
    assign mem_addr  = mem_en ? g_addr[9:0] : 10'd0;
    assign mem_wdata = mem_en ? g_wdata : 8'h00;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (gnt_vec[1]) begin
            starve_cnt_next = '0;
        end else if (gnt_vec[0] && dma_req && !starved) begin
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        src_next = SRC_ZERO;
        if (hit_ram) begin
            src_next = SRC_RAM;
        end else if (hit_sw) begin
            src_next = SRC_SW;
        end
    end

    // rdata follows the return source during a return cycle and holds otherwise.
    always_comb begin
        rdata_next = rdata_last_reg;
        if (|pend_reg) begin
            case (src_reg)
                SRC_RAM: rdata_next = mem_rdata;
                SRC_SW:  rdata_next = sw_sample_reg;
                default: rdata_next = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
            pend_reg       <= '0;
            src_reg        <= SRC_ZERO;
            sw_sample_reg  <= 8'h00;
            led_reg        <= 8'h00;
            rdata_last_reg <= 8'h00;
            bus_err_reg    <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            pend_reg       <= rd_gnt_vec;
            rdata_last_reg <= rdata_next;
            bus_err_reg    <= grant_any & hit_none;
            if (|rd_gnt_vec) begin
                src_reg <= src_next;
                if (hit_sw) begin
                    sw_sample_reg <= sw;
                end
            end
            if (grant_any && g_we && hit_led) begin
                led_reg <= g_wdata;
            end
        end
    end

    // A return due in a reset cycle is suppressed rather than delivered.
    assign cpu_rvalid = pend_reg[0] & ~rst;
    assign dma_rvalid = pend_reg[1] & ~rst;
    assign bus_err    = bus_err_reg & ~rst;
    assign rdata      = rst ? 8'h00 : rdata_next;
    assign led        = led_reg;

endmodule

// File: doc/waffle_bus_arbiter.md
# waffle_bus_arbiter

Shares the single WAFFLE memory port between the CPU core and a secondary bus master (DMA / boot loader). Grants at most one access per clock and decodes the 16-bit address into RAM, the switch input (998), the LED register (999) or an unmapped hole. Returns read data one cycle after the grant. CPU has default priority; a starvation counter guarantees the secondary master forward progress.

## Interface
- RAM_LIMIT, 900: addresses below this map to RAM.
- SW_ADDR, 998: read-only switch port address.
- LED_ADDR, 999: write-only LED register address.
- STARVE_MAX, 4: consecutive lost contentions after which the DMA master wins.

- clk  in  1  system clock; one clock only, all state on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  16  CPU byte address.
- cpu_wdata  in  8  CPU write data.
- cpu_gnt  out  1  CPU access issued this cycle (combinational).
- cpu_rvalid  out  1  CPU read data valid (registered).
- dma_req, dma_we, dma_addr[15:0], dma_wdata[7:0]  in  as CPU.
- dma_gnt  out  1  DMA access issued this cycle.
- dma_rvalid  out  1  DMA read data valid.
- rdata  out  8  shared read-return data, qualified by the *_rvalid strobes.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  10  RAM address (low bits of granted address).
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data, valid one cycle after mem_en.
- sw  in  8  switch inputs.
- led  out  8  LED register.
- bus_err  out  1  one-cycle pulse: granted access hit an unmapped address.

## Operation
- Requesters hold req/we/addr/wdata stable until their gnt is seen high.
- Arbitration (combinational each cycle, never outside rst=0):
  - only one req high: that requester granted.
  - both high: CPU granted unless starve_cnt == STARVE_MAX, then DMA granted.
  - cpu_gnt and dma_gnt are never high together.
- starve_cnt (width to hold STARVE_MAX): +1 each cycle both requested and CPU won; cleared on any DMA grant; saturates at STARVE_MAX; unchanged when DMA not requesting.
- Decode of granted address:
  - addr < RAM_LIMIT: mem_en=1, mem_we=we, mem_addr=addr[9:0], mem_wdata=wdata.
  - addr == LED_ADDR, write: led <= wdata. Read: returns 0.
  - addr == SW_ADDR, read: sw sampled at end of grant cycle. Write: dropped.
  - any other address: write dropped, read returns 0, bus_err pulses next cycle.
- Read return: registered owner (cpu/dma) and source (ram/sw/zero) from the grant cycle; next cycle exactly one *_rvalid high, rdata = mem_rdata, sampled sw, or 0 per source.
- Writes produce no rvalid.
- No grant: mem_en=0, mem_we=0, rdata holds last value.

## Timing
- Grant: same cycle as req (zero-latency, combinational from req and starve_cnt).
- Read latency: rvalid/rdata exactly 1 cycle after gnt; back-to-back grants every cycle sustain one read return per cycle.
- LED write visible on led the cycle after gnt.
- bus_err asserted the cycle after the offending grant, for one cycle.
- Reset values: led=0, cpu_rvalid=0, dma_rvalid=0, rdata=0, bus_err=0, starve_cnt=0, owner/source cleared. While rst=1: cpu_gnt=dma_gnt=0, mem_en=mem_we=0.
- Reset asserted the cycle after a read grant: that rvalid is suppressed.
- Boundaries: addr 899 → RAM; addr 900 → unmapped; 0xFFFF → unmapped; mem_addr never driven for addr ≥ RAM_LIMIT.

## Test plan
- CPU-only: write 0x5A to 0x0010, then read 0x0010 → cpu_gnt same cycle, cpu_rvalid=1 with rdata=0x5A one cycle after read grant; dma_rvalid stays 0.
- MMIO: CPU write 0xC3 to 999 → led=0xC3 next cycle, mem_en=0; sw=0x81, read 998 → rdata=0x81; read 999 → rdata=0x00.
- Contention/starvation: both req held continuously with STARVE_MAX=4 → grants C,C,C,C,D,C,C,C,C,D…; never both gnt high.
- Unmapped: DMA write 0x77 to 900 → bus_err pulse next cycle, no RAM write (subsequent RAM reads unchanged), no dma_rvalid; read 0x0400 → dma_rvalid, rdata=0, bus_err pulse.
- Pipelined reads: CPU reads 0x0001, DMA reads 0x0002 on consecutive cycles (RAM preloaded 0x11/0x22) → cpu_rvalid with 0x11 then dma_rvalid with 0x22 in consecutive cycles.
- Reset mid-op: rst high the cycle after a CPU read grant → no cpu_rvalid, led=0, starve_cnt=0; first request after rst release granted immediately.
